// File: rtl/mem_stage_ctrl_pkg.sv
// mips_pkg: types and bit positions shared by the MEM-stage controller files.
//   mem_state_t : controller state (IDLE, REQ)
//   REGWRITE / MEMTOREG : bit positions inside the 2-bit WB control field
//   ERR_* : bit positions inside the sticky mem_err vector
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  localparam int ERR_TIMEOUT  = 2;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_RWCONF   = 0;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus.
//   dmem_req   : request valid (master -> slave)
//   dmem_we    : 1 = write
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : write data
//   dmem_ack   : slave completes the request this cycle (slave -> master)
//   dmem_rdata : read data, valid with dmem_ack
interface mem_stage_ctrl_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb.sv
// MEM/WB pipeline register with synchronous active-high reset and load enable.
//   clk, reset        : clock, synchronous reset (clears every field)
//   load              : capture the *_in fields at the rising edge
//   ctl/memdata/alu/dest/valid _in : next slot contents
//   wb_*              : registered slot contents
module mem_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  ctl_in,
  input  logic [31:0] memdata_in,
  input  logic [31:0] alu_in,
  input  logic [4:0]  dest_in,
  input  logic        valid_in,
  output logic [1:0]  wb_ctl,
  output logic [31:0] wb_memdata,
  output logic [31:0] wb_alu,
  output logic [4:0]  wb_dest,
  output logic        wb_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ctl     <= '0;
      wb_memdata <= '0;
      wb_alu     <= '0;
      wb_dest    <= '0;
      wb_valid   <= 1'b0;
    end else if (load) begin
      wb_ctl     <= ctl_in;
      wb_memdata <= memdata_in;
      wb_alu     <= alu_in;
      wb_dest    <= dest_in;
      wb_valid   <= valid_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: resolves branches, runs the data-memory req/ack
// handshake with a timeout, stalls upstream while an access is outstanding
// and loads the MEM/WB register.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid .. dest_reg  : EX/MEM register outputs (held while stall = 1)
//   pcsrc, branch_target  : branch resolution (combinational)
//   stall                 : hold PC, IF/ID, ID/EX, EX/MEM
//   dmem                  : data-memory bus (master side)
//   wb_*                  : MEM/WB register outputs
//   mem_err               : sticky {timeout, misaligned, read/write conflict}
//
// state | meaning
// IDLE  | accept a slot; non-mem and illegal slots retire in one cycle
// REQ   | request outstanding, waiting for dmem_ack or timeout
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [1:0]            ctlwb_in,
  input  logic                  branch,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [31:0]           add_result,
  input  logic                  zero,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           rdata2,
  input  logic [4:0]            dest_reg,
  output logic                  pcsrc,
  output logic [31:0]           branch_target,
  output logic                  stall,
  mem_stage_ctrl_if.master      dmem,
  output logic [1:0]            wb_ctl,
  output logic [31:0]           wb_memdata,
  output logic [31:0]           wb_alu,
  output logic [4:0]            wb_dest,
  output logic                  wb_valid,
  output logic [2:0]            mem_err
);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;

  logic memop, rw_conf, misalign, illegal, legal_memop, tmo;

  assign pcsrc         = in_valid & branch & zero;
  assign branch_target = add_result;

  assign memop       = in_valid & (memread | memwrite);
  assign rw_conf     = memread & memwrite;
  assign misalign    = (alu_result[1:0] != 2'b00);
  assign illegal     = memop & (rw_conf | misalign);
  assign legal_memop = memop & ~illegal;

  // Ack wins over timeout when both land on the terminal-count cycle.
  assign tmo = (state == REQ) & ~dmem.dmem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES));

  assign stall = ((state == IDLE) & legal_memop) |
                 ((state == REQ) & ~dmem.dmem_ack & ~tmo);

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && rw_conf)  mem_err[ERR_RWCONF]   <= 1'b1;
          if (memop && misalign) mem_err[ERR_MISALIGN] <= 1'b1;
          if (legal_memop) begin
            state   <= REQ;
            cnt     <= '0;
            req_q   <= 1'b1;
            we_q    <= memwrite;
            addr_q  <= {alu_result[31:2], 2'b00};
            wdata_q <= rdata2;
          end
        end
        REQ: begin
          if (dmem.dmem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end else if (tmo) begin
            state                <= IDLE;
            req_q                <= 1'b0;
            mem_err[ERR_TIMEOUT] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next MEM/WB contents. A stalled cycle inserts a bubble once, then holds.
  logic [1:0]  ctl_d;
  logic [31:0] memdata_d;
  logic [31:0] alu_d;
  logic [4:0]  dest_d;
  logic        valid_d;
  logic        wb_load;

  always_comb begin
    ctl_d     = ctlwb_in;
    memdata_d = '0;
    alu_d     = alu_result;
    dest_d    = dest_reg;
    valid_d   = in_valid;
    if (state == REQ) begin
      if (tmo)        ctl_d[REGWRITE] = 1'b0;
      else if (!we_q) memdata_d = dmem.dmem_rdata;
    end else if (illegal) begin
      ctl_d[REGWRITE] = 1'b0;
    end
    if (stall) begin
      ctl_d     = '0;
      memdata_d = '0;
      alu_d     = '0;
      dest_d    = '0;
      valid_d   = 1'b0;
    end
  end

  assign wb_load = ~stall | wb_valid;

  mem_wb u_mem_wb (
    .clk        (clk),
    .reset      (reset),
    .load       (wb_load),
    .ctl_in     (ctl_d),
    .memdata_in (memdata_d),
    .alu_in     (alu_d),
    .dest_in    (dest_d),
    .valid_in   (valid_d),
    .wb_ctl     (wb_ctl),
    .wb_memdata (wb_memdata),
    .wb_alu     (wb_alu),
    .wb_dest    (wb_dest),
    .wb_valid   (wb_valid)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT_CYCLES = 4).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, branch, memread, memwrite, zero;
  logic [1:0]  ctlwb_in;
  logic [31:0] add_result, alu_result, rdata2;
  logic [4:0]  dest_reg;
  logic        pcsrc, stall, wb_valid;
  logic [31:0] branch_target, wb_memdata, wb_alu;
  logic [1:0]  wb_ctl;
  logic [4:0]  wb_dest;
  logic [2:0]  mem_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage_ctrl_if dmem ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .ctlwb_in      (ctlwb_in),
    .branch        (branch),
    .memread       (memread),
    .memwrite      (memwrite),
    .add_result    (add_result),
    .zero          (zero),
    .alu_result    (alu_result),
    .rdata2        (rdata2),
    .dest_reg      (dest_reg),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .dmem          (dmem.master),
    .wb_ctl        (wb_ctl),
    .wb_memdata    (wb_memdata),
    .wb_alu        (wb_alu),
    .wb_dest       (wb_dest),
    .wb_valid      (wb_valid),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; branch = 0; memread = 0; memwrite = 0; zero = 0;
    ctlwb_in = 0; add_result = 0; alu_result = 0; rdata2 = 0; dest_reg = 0;
    dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
  endtask

  // Runs one memory slot already presented on the inputs. ack_at = index of
  // the REQ cycle carrying dmem_ack (0 = never). Ends on the first cycle
  // with stall low, after clocking that cycle in.
  task automatic run_mem(input string tag, input int ack_at, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic [31:0] exp_wdata,
                         output int n_stall, output int n_req, output bit done);
    n_stall = 0; n_req = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (dmem.dmem_req) begin
        n_req++;
        chk({tag, "_addr"}, dmem.dmem_addr, exp_addr);
        chk({tag, "_we"}, {31'b0, dmem.dmem_we}, {31'b0, exp_we});
        if (exp_we) chk({tag, "_wdata"}, dmem.dmem_wdata, exp_wdata);
      end
      dmem.dmem_ack   = (ack_at > 0) && (n_req == ack_at);
      dmem.dmem_rdata = dmem.dmem_ack ? rdata : 32'h0;
      #1;
      if (stall) n_stall++;
      else done = 1;
      tick();
    end
    dmem.dmem_ack = 0;
    dmem.dmem_rdata = 0;
  endtask

  int n_stall, n_req;
  bit done;

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("rst_wb_alu", wb_alu, 0);
    chk("rst_mem_err", {29'b0, mem_err}, 0);
    chk("rst_req", {31'b0, dmem.dmem_req}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    reset = 0;

    // ALU op
    in_valid = 1; ctlwb_in = 2'b10; alu_result = 32'h1234; dest_reg = 5;
    #1 chk("alu_stall", {31'b0, stall}, 0);
    tick();
    chk("alu_wb_alu", wb_alu, 32'h1234);
    chk("alu_wb_dest", {27'b0, wb_dest}, 5);
    chk("alu_wb_valid", {31'b0, wb_valid}, 1);
    chk("alu_wb_ctl", {30'b0, wb_ctl}, 2'b10);
    chk("alu_wb_memdata", wb_memdata, 0);

    // bubble
    in_valid = 0;
    tick();
    chk("bub_wb_valid", {31'b0, wb_valid}, 0);
    chk("bub_req", {31'b0, dmem.dmem_req}, 0);

    // branch resolution
    in_valid = 1; branch = 1; zero = 1; add_result = 32'h40;
    #1;
    chk("br_pcsrc_taken", {31'b0, pcsrc}, 1);
    chk("br_target", branch_target, 32'h40);
    zero = 0;
    #1 chk("br_pcsrc_not", {31'b0, pcsrc}, 0);
    tick();
    clear_inputs();

    // load, ack on 4th REQ cycle
    in_valid = 1; memread = 1; alu_result = 32'h100; ctlwb_in = 2'b11; dest_reg = 7;
    run_mem("ld", 4, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0, n_stall, n_req, done);
    chk("ld_done", {31'b0, done}, 1);
    chk("ld_stall_cycles", n_stall, 4);
    chk("ld_req_cycles", n_req, 4);
    chk("ld_wb_memdata", wb_memdata, 32'hDEADBEEF);
    chk("ld_wb_ctl", {30'b0, wb_ctl}, 2'b11);
    chk("ld_wb_dest", {27'b0, wb_dest}, 7);
    chk("ld_wb_valid", {31'b0, wb_valid}, 1);
    chk("ld_req_drop", {31'b0, dmem.dmem_req}, 0);
    clear_inputs();

    // store, ack on first REQ cycle
    in_valid = 1; memwrite = 1; alu_result = 32'h204; rdata2 = 32'hA5A5A5A5;
    ctlwb_in = 2'b00; dest_reg = 2;
    run_mem("st", 1, 32'h12345678, 32'h204, 1'b1, 32'hA5A5A5A5, n_stall, n_req, done);
    chk("st_done", {31'b0, done}, 1);
    chk("st_stall_cycles", n_stall, 1);
    chk("st_req_cycles", n_req, 1);
    chk("st_wb_ctl", {30'b0, wb_ctl}, 2'b00);
    chk("st_wb_memdata", wb_memdata, 0);
    chk("st_wb_alu", wb_alu, 32'h204);
    chk("st_wb_valid", {31'b0, wb_valid}, 1);
    clear_inputs();

    // misaligned load
    in_valid = 1; memread = 1; alu_result = 32'h103; ctlwb_in = 2'b11; dest_reg = 3;
    #1 chk("mis_stall", {31'b0, stall}, 0);
    tick();
    chk("mis_req", {31'b0, dmem.dmem_req}, 0);
    chk("mis_err", {29'b0, mem_err}, 3'b010);
    chk("mis_wb_ctl", {30'b0, wb_ctl}, 2'b01);
    chk("mis_wb_memdata", wb_memdata, 0);
    chk("mis_wb_valid", {31'b0, wb_valid}, 1);
    clear_inputs();
    tick();
    chk("mis_req_after", {31'b0, dmem.dmem_req}, 0);

    // read/write conflict
    in_valid = 1; memread = 1; memwrite = 1; alu_result = 32'h200; ctlwb_in = 2'b10;
    #1 chk("rw_stall", {31'b0, stall}, 0);
    tick();
    chk("rw_req", {31'b0, dmem.dmem_req}, 0);
    chk("rw_err", {29'b0, mem_err}, 3'b011);
    chk("rw_wb_ctl", {30'b0, wb_ctl}, 2'b00);
    clear_inputs();

    // timeout: REQ cycles with count 0..3 wait, count 4 abandons
    in_valid = 1; memread = 1; alu_result = 32'h300; ctlwb_in = 2'b11; dest_reg = 9;
    run_mem("tmo", 0, 32'h0, 32'h300, 1'b0, 32'h0, n_stall, n_req, done);
    chk("tmo_done", {31'b0, done}, 1);
    chk("tmo_req_cycles", n_req, 5);
    chk("tmo_stall_cycles", n_stall, 5);
    chk("tmo_err", {29'b0, mem_err}, 3'b111);
    chk("tmo_wb_ctl", {30'b0, wb_ctl}, 2'b01);
    chk("tmo_wb_memdata", wb_memdata, 0);
    chk("tmo_wb_valid", {31'b0, wb_valid}, 1);
    chk("tmo_req_drop", {31'b0, dmem.dmem_req}, 0);
    clear_inputs();

    // reset mid-REQ
    in_valid = 1; memread = 1; alu_result = 32'h400; ctlwb_in = 2'b11; dest_reg = 4;
    tick(); tick();
    chk("mid_req_active", {31'b0, dmem.dmem_req}, 1);
    chk("mid_stall", {31'b0, stall}, 1);
    reset = 1;
    clear_inputs();
    tick();
    chk("mid_rst_req", {31'b0, dmem.dmem_req}, 0);
    chk("mid_rst_err", {29'b0, mem_err}, 0);
    chk("mid_rst_wb_valid", {31'b0, wb_valid}, 0);
    chk("mid_rst_wb_alu", wb_alu, 0);
    chk("mid_rst_wb_ctl", {30'b0, wb_ctl}, 0);
    chk("mid_rst_stall", {31'b0, stall}, 0);
    reset = 0;
    tick();
    chk("post_rst_req", {31'b0, dmem.dmem_req}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
